// File: rtl/mem_channel_arb_n.sv
// N-channel arbiter in front of a single DDR controller port: one outstanding
// command, fixed-priority or round-robin grant, registered response, completion timeout.
module mem_channel_arb_n #(
    parameter int NUM_CH         = 2,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 512,
    parameter int ARB_MODE       = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CH-1:0]            req_write,
    input  logic [NUM_CH-1:0]            req_burst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_CH-1:0]            resp_done,
    output logic                         resp_err,
    output logic [DATA_WIDTH-1:0]        resp_rdata,
    output logic                         ddr_chip_enable,
    output logic [ADDR_WIDTH-1:0]        ddr_index,
    output logic                         ddr_write_enable,
    output logic                         ddr_burst_mode,
    output logic [DATA_WIDTH-1:0]        ddr_write_data,
    input  logic [DATA_WIDTH-1:0]        ddr_read_data,
    input  logic                         ddr_operation_done,
    input  logic                         ddr_ready
);

    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit TMO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic                  burst;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    state_t state_q, state_d;

    logic [NUM_CH-1:0][ADDR_WIDTH-1:0] addr_a;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] wdata_a;

    logic [CH_W-1:0]  rr_ptr, owner, grant_idx, ptr_next, scan_base;
    logic [CH_W:0]    scan_idx;
    logic             found;
    logic             fire, done_hit, tmo_hit;
    logic [CNT_W-1:0] tmo_cnt;
    cmd_t             grant_cmd, cmd_q;

    assign addr_a  = req_addr;
    assign wdata_a = req_wdata;

    // Scan from the start point, wrapping once; fixed priority always starts at 0.
    assign scan_base = (ARB_MODE != 0) ? rr_ptr : '0;

    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = {1'b0, scan_base} + (CH_W+1)'(i);
            if (scan_idx >= (CH_W+1)'(NUM_CH))
                scan_idx = scan_idx - (CH_W+1)'(NUM_CH);
            if (!found && req_valid[scan_idx[CH_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = scan_idx[CH_W-1:0];
            end
        end
    end

    assign ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        grant_cmd.addr  = addr_a[grant_idx];
        grant_cmd.write = req_write[grant_idx];
        grant_cmd.burst = req_burst[grant_idx];
        grant_cmd.wdata = wdata_a[grant_idx];
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        fire      = 1'b0;
        done_hit  = 1'b0;
        tmo_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by reset so the handshake is quiet while reset is held.
                if (!reset && ddr_ready && found) begin
                    req_ready = NUM_CH'(1) << grant_idx;
                    fire      = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (ddr_operation_done) begin
                    done_hit = 1'b1;
                    state_d  = RESP;
                end else if (TMO_EN && tmo_cnt == CNT_W'(TMO_LAST)) begin
                    tmo_hit = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr          <= '0;
            owner           <= '0;
            cmd_q           <= '0;
            tmo_cnt         <= '0;
            ddr_chip_enable <= 1'b0;
            resp_done       <= '0;
            resp_err        <= 1'b0;
            resp_rdata      <= '0;
        end else begin
            ddr_chip_enable <= fire;
            resp_done       <= '0;
            resp_err        <= 1'b0;
            if (fire) begin
                owner <= grant_idx;
                cmd_q <= grant_cmd;
                if (ARB_MODE != 0) rr_ptr <= ptr_next;
            end
            if (state_q == ISSUE)     tmo_cnt <= '0;
            else if (state_q == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
            // On timeout resp_rdata keeps the last completed read.
            if (done_hit) resp_rdata <= ddr_read_data;
            if (done_hit || tmo_hit) begin
                resp_done <= NUM_CH'(1) << owner;
                resp_err  <= tmo_hit;
            end
        end
    end

    assign ddr_index        = cmd_q.addr;
    assign ddr_write_enable = cmd_q.write;
    assign ddr_burst_mode   = cmd_q.burst;
    assign ddr_write_data   = cmd_q.wdata;

endmodule

// File: tb/tb_mem_channel_arb_n.sv
// Bench for mem_channel_arb_n: a round-robin and a fixed-priority instance share
// all inputs; expected grants/commands/responses come from a transaction-level model.
module tb_mem_channel_arb_n;

    localparam int N   = 4;
    localparam int AW  = 64;
    localparam int DW  = 128;
    localparam int TMO = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_write, req_burst;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   ddr_read_data;
    logic            ddr_operation_done, ddr_ready;

    logic [N-1:0]    rdy_r, rdy_f, done_r, done_f;
    logic            err_r, err_f, ce_r, ce_f, we_r, we_f, bm_r, bm_f;
    logic [DW-1:0]   rdata_r, rdata_f, wd_r, wd_f;
    logic [AW-1:0]   idx_r, idx_f;

    logic [AW-1:0]   a_m [N];
    logic [DW-1:0]   d_m [N];
    int              n_tests = 0, n_fail = 0;
    int              rr_m = 0;
    logic [DW-1:0]   rd_m = '0;

    typedef struct {
        logic [N-1:0] vld;
        logic         rdy;
        int           exp_r;
        int           exp_f;
    } vec_t;
    vec_t tbl [13];

    mem_channel_arb_n #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .ARB_MODE(1), .TIMEOUT_CYCLES(TMO)) u_rr (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy_r),
        .req_addr(req_addr), .req_write(req_write), .req_burst(req_burst),
        .req_wdata(req_wdata), .resp_done(done_r), .resp_err(err_r),
        .resp_rdata(rdata_r), .ddr_chip_enable(ce_r), .ddr_index(idx_r),
        .ddr_write_enable(we_r), .ddr_burst_mode(bm_r), .ddr_write_data(wd_r),
        .ddr_read_data(ddr_read_data), .ddr_operation_done(ddr_operation_done),
        .ddr_ready(ddr_ready));

    mem_channel_arb_n #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .ARB_MODE(0), .TIMEOUT_CYCLES(TMO)) u_fp (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy_f),
        .req_addr(req_addr), .req_write(req_write), .req_burst(req_burst),
        .req_wdata(req_wdata), .resp_done(done_f), .resp_err(err_f),
        .resp_rdata(rdata_f), .ddr_chip_enable(ce_f), .ddr_index(idx_f),
        .ddr_write_enable(we_f), .ddr_burst_mode(bm_f), .ddr_write_data(wd_f),
        .ddr_read_data(ddr_read_data), .ddr_operation_done(ddr_operation_done),
        .ddr_ready(ddr_ready));

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] oh(input int g);
        return (g < 0) ? 256'd0 : (256'd1 << g);
    endfunction

    // Reference grant rules: first valid at/after the pointer (wrapping), or lowest valid.
    function automatic int g_rr(input logic [N-1:0] v, input logic r);
        if (!r || v == '0) return -1;
        for (int k = 0; k < N; k++)
            if (v[(rr_m + k) % N]) return (rr_m + k) % N;
        return -1;
    endfunction

    function automatic int g_fp(input logic [N-1:0] v, input logic r);
        if (!r || v == '0) return -1;
        for (int k = 0; k < N; k++)
            if (v[k]) return k;
        return -1;
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = a_m[i];
            req_wdata[i*DW +: DW] = d_m[i];
        end
    endtask

    task automatic rand_ch();
        for (int i = 0; i < N; i++) begin
            a_m[i] = {$urandom, $urandom};
            d_m[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        req_write = N'($urandom);
        req_burst = N'($urandom);
        pack();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_resp_rr"}, {rdy_r, done_r, err_r, rdata_r}, '0);
        chk({tag, "_resp_fp"}, {rdy_f, done_f, err_f, rdata_f}, '0);
        chk({tag, "_ddr_rr"},  {ce_r, idx_r, we_r, bm_r, wd_r}, '0);
        chk({tag, "_ddr_fp"},  {ce_f, idx_f, we_f, bm_f, wd_f}, '0);
    endtask

    // Entered and left at a negedge in IDLE. k = WAIT cycle carrying done (1 = first),
    // k outside 1..TMO means the controller never answers in time.
    task automatic run_txn(input logic [N-1:0] vld, input logic rdy, input int er,
                           input int ef, input int k, input logic spur,
                           input logic [DW-1:0] rdat);
        logic [AW-1:0] ea_r, ea_f;
        logic [DW-1:0] ed_r, ed_f;
        logic          ew_r, ew_f, eb_r, eb_f, terr;
        int            j_end;
        req_valid = vld;
        ddr_ready = rdy;
        ddr_operation_done = 1'b0;
        pack();
        #1;
        chk("idle_req_ready_rr", rdy_r, oh(er));
        chk("idle_req_ready_fp", rdy_f, oh(ef));
        if (er < 0 || ef < 0) begin
            @(negedge clock);
            chk("no_issue_ce_rr", ce_r, 0);
            chk("no_issue_ce_fp", ce_f, 0);
            req_valid = '0;
            return;
        end
        ea_r = a_m[er]; ed_r = d_m[er]; ew_r = req_write[er]; eb_r = req_burst[er];
        ea_f = a_m[ef]; ed_f = d_m[ef]; ew_f = req_write[ef]; eb_f = req_burst[ef];
        rr_m = (er + 1) % N;
        @(negedge clock);
        rand_ch();
        req_valid = N'($urandom);
        ddr_operation_done = spur;
        #1;
        chk("issue_ce_rr", ce_r, 1);
        chk("issue_ce_fp", ce_f, 1);
        chk("issue_index_rr", idx_r, ea_r);
        chk("issue_index_fp", idx_f, ea_f);
        chk("issue_we_rr", we_r, ew_r);
        chk("issue_we_fp", we_f, ew_f);
        chk("issue_burst_rr", bm_r, eb_r);
        chk("issue_burst_fp", bm_f, eb_f);
        chk("issue_wdata_rr", wd_r, ed_r);
        chk("issue_wdata_fp", wd_f, ed_f);
        chk("issue_ready_rr", rdy_r, 0);
        terr  = !(k >= 1 && k <= TMO);
        j_end = terr ? TMO : k;
        for (int j = 1; j <= j_end; j++) begin
            @(negedge clock);
            ddr_operation_done = (j == k);
            ddr_read_data = (j == k) ? rdat : {$urandom, $urandom, $urandom, $urandom};
            if (j == k) rd_m = rdat;
            #1;
            chk("wait_no_done_rr", done_r, 0);
            chk("wait_no_done_fp", done_f, 0);
            if (j == 1) begin
                chk("ce_one_cycle_rr", ce_r, 0);
                chk("wait_ready_fp", rdy_f, 0);
            end
            if (j == j_end) begin
                chk("held_index_rr", idx_r, ea_r);
                chk("held_wdata_fp", wd_f, ed_f);
            end
        end
        @(negedge clock);
        ddr_operation_done = spur;
        ddr_read_data = {$urandom, $urandom, $urandom, $urandom};
        #1;
        chk("resp_done_rr", done_r, oh(er));
        chk("resp_done_fp", done_f, oh(ef));
        chk("resp_err_rr", err_r, terr);
        chk("resp_err_fp", err_f, terr);
        chk("resp_rdata_rr", rdata_r, rd_m);
        chk("resp_rdata_fp", rdata_f, rd_m);
        chk("resp_ready_rr", rdy_r, 0);
        @(negedge clock);
        ddr_operation_done = 1'b0;
        req_valid = '0;
        chk("done_pulse_rr", done_r, 0);
        chk("done_pulse_fp", done_f, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b1111, 1'b1, 2, 0};
        tbl[1]  = '{4'b1111, 1'b1, 3, 0};
        tbl[2]  = '{4'b1111, 1'b1, 0, 0};
        tbl[3]  = '{4'b1111, 1'b1, 1, 0};
        tbl[4]  = '{4'b1111, 1'b1, 2, 0};
        tbl[5]  = '{4'b0101, 1'b1, 0, 0};
        tbl[6]  = '{4'b0101, 1'b1, 2, 0};
        tbl[7]  = '{4'b0100, 1'b1, 2, 2};
        tbl[8]  = '{4'b1111, 1'b0, -1, -1};
        tbl[9]  = '{4'b0000, 1'b1, -1, -1};
        tbl[10] = '{4'b1000, 1'b1, 3, 3};
        tbl[11] = '{4'b0110, 1'b1, 1, 1};
        tbl[12] = '{4'b1001, 1'b1, 3, 0};

        // Reset with live requests: everything must stay quiet.
        reset = 1'b1;
        req_valid = '1;
        ddr_ready = 1'b1;
        ddr_operation_done = 1'b0;
        ddr_read_data = '0;
        rand_ch();
        repeat (3) @(negedge clock);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        req_valid = '0;

        // Single read on ch1, done 5 cycles after ISSUE.
        rand_ch();
        a_m[1] = 64'h8000_0040;
        req_write = '0;
        req_burst = 4'b0010;
        run_txn(4'b0010, 1'b1, 1, 1, 5, 1'b0, {16{8'hA5}});

        for (int i = 0; i < 13; i++) begin
            rand_ch();
            run_txn(tbl[i].vld, tbl[i].rdy, tbl[i].exp_r, tbl[i].exp_f,
                    (i % 4) + 1, i[0], {$urandom, $urandom, $urandom, $urandom});
        end

        // Timeout with no done, then done landing on the timeout cycle.
        rand_ch();
        run_txn(4'b0010, 1'b1, 1, 1, 0, 1'b0, '0);
        rand_ch();
        run_txn(4'b1000, 1'b1, 3, 3, TMO, 1'b0, {4{32'hC0DE_0001}});

        // Write on ch0; inputs scrambled after fire must not reach the DDR command.
        rand_ch();
        a_m[0] = 64'h100;
        d_m[0] = {4{32'h1234_5678}};
        req_write = 4'b0001;
        run_txn(4'b0001, 1'b1, 0, 0, 3, 1'b1, {$urandom, $urandom, $urandom, $urandom});

        // DDR backpressure.
        rand_ch();
        req_valid = '1;
        ddr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_ready_rr", rdy_r, 0);
            chk("bp_ready_fp", rdy_f, 0);
            @(negedge clock);
            chk("bp_no_ce_rr", ce_r, 0);
        end
        run_txn(4'b1111, 1'b1, g_rr(4'b1111, 1'b1), g_fp(4'b1111, 1'b1), 3, 1'b0,
                {$urandom, $urandom, $urandom, $urandom});

        // Reset during WAIT, followed by a stale completion.
        rand_ch();
        a_m[2] = 64'hDEAD_BEEF_0000_0200;
        req_write = 4'b0100;
        pack();
        req_valid = 4'b0100;
        ddr_ready = 1'b1;
        @(negedge clock);
        req_valid = '0;
        chk("rst_seq_issue_rr", idx_r, 64'hDEAD_BEEF_0000_0200);
        @(negedge clock);
        reset = 1'b1;
        req_valid = '1;
        @(negedge clock);
        #1;
        chk_zero("reset_in_wait");
        reset = 1'b0;
        req_valid = '0;
        rr_m = 0;
        rd_m = '0;
        ddr_operation_done = 1'b1;
        ddr_read_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clock);
        ddr_operation_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("late_done_rr", done_r, 0);
            chk("late_done_fp", done_f, 0);
            chk("late_done_ce_rr", ce_r, 0);
            @(negedge clock);
        end

        // Round-robin fairness from reset: 0,1,2,3,0,1; fixed priority stays on 0.
        for (int i = 0; i < 6; i++) begin
            rand_ch();
            run_txn(4'b1111, 1'b1, i % N, 0, 2, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        end

        for (int i = 0; i < 60; i++) begin
            logic [N-1:0] v;
            logic         r;
            rand_ch();
            v = N'($urandom);
            r = ($urandom_range(0, 4) != 0);
            run_txn(v, r, g_rr(v, r), g_fp(v, r), $urandom_range(0, 10),
                    1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_channel_arb_n.md
Name: mem_channel_arb_n

Overview:
- Parametrised N-channel arbiter between cache/bus clients and the single DDR controller interface; successor of the fixed two-channel icache/dcache arbiter.
- Adds selectable fixed-priority or round-robin arbitration, per-request burst/write mode, a registered response path and a DDR completion timeout with error reporting.
- Sits in the core top between the icache, the dcache and any additional masters (e.g. PTW or prefetcher) and the external DDR ports.

Parameters:
NUM_CH, 2, number of client channels (2..8)
ADDR_WIDTH, 64, request/DDR index width
DATA_WIDTH, 512, cacheline data width
ARB_MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round-robin
TIMEOUT_CYCLES, 1024, maximum WAIT cycles before error completion (0 disables the timeout)

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-high
req_valid  in  NUM_CH  per-channel request valid
req_ready  out  NUM_CH  per-channel accept; fire = valid & ready
req_addr  in  NUM_CH*ADDR_WIDTH  flattened addresses; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_write  in  NUM_CH  1 = write, 0 = read
req_burst  in  NUM_CH  burst mode request
req_wdata  in  NUM_CH*DATA_WIDTH  flattened write data
resp_done  out  NUM_CH  one-cycle completion pulse to the owning channel
resp_err  out  1  qualifies resp_done: 1 = timeout
resp_rdata  out  DATA_WIDTH  read data, valid while resp_done is asserted
ddr_chip_enable  out  1  one-cycle command strobe
ddr_index  out  ADDR_WIDTH  command address
ddr_write_enable  out  1  command write
ddr_burst_mode  out  1  command burst
ddr_write_data  out  DATA_WIDTH  command write data
ddr_read_data  in  DATA_WIDTH  DDR read data
ddr_operation_done  in  1  DDR completion pulse
ddr_ready  in  1  DDR can accept a command

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; rr_ptr = 0; timeout counter = 0.
  - All outputs are 0: req_ready, resp_done, resp_err, resp_rdata, ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode, ddr_write_data.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Only one transaction is outstanding at a time.
- IDLE:
  - req_ready is combinational: onehot(grant) when ddr_ready = 1 and any req_valid is set; 0 otherwise.
  - Grant selection, fixed priority: lowest-index valid channel.
  - Grant selection, round-robin: first valid channel at or after rr_ptr, wrapping modulo NUM_CH.
  - On fire: latch owner, addr, write, burst and wdata into the ddr_* registers; go to ISSUE. In round-robin mode, rr_ptr <= (owner + 1) mod NUM_CH.
- ISSUE:
  - ddr_chip_enable = 1 for exactly this cycle.
  - ddr_index, ddr_write_enable, ddr_burst_mode and ddr_write_data are held from here until the state leaves WAIT.
  - Go to WAIT; clear the timeout counter.
- WAIT:
  - Counter increments each cycle.
  - On ddr_operation_done: register ddr_read_data into resp_rdata; go to RESP.
  - Else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES - 1: set the error flag; go to RESP. resp_rdata keeps its previous value.
  - A ddr_operation_done in the same cycle as the timeout wins: no error is reported.
- RESP:
  - resp_done[owner] = 1 and resp_err = error flag, for one cycle.
  - Next state is IDLE; the error flag is cleared.
  - On a write, resp_rdata holds whatever DDR returned; it is don't-care to clients.
- Latency: request fire to chip_enable is 1 cycle; ddr_operation_done to resp_done is 1 cycle. Minimum end-to-end is 4 cycles when done arrives the cycle after ISSUE.
- ddr_operation_done outside WAIT is ignored.
- A request withdrawn before fire is dropped silently; no state is affected.
- req_ready is never asserted outside IDLE; a new request is first accepted in the cycle after RESP.
- Reset mid-transaction aborts it: no resp_done, and a late ddr_operation_done after reset is ignored.
- NUM_CH = 1: the arbiter degenerates to pass-through registration; rr_ptr stays 0.

Test Plan:
1. Single read: ch1 requests addr 0x8000_0040, read, burst = 1 -> next cycle chip_enable = 1 with index 0x8000_0040, write_enable = 0, burst = 1. DDR done 5 cycles later with data 0xA5.. -> one cycle later resp_done = 2'b10, resp_rdata = 0xA5.., resp_err = 0.
2. Round-robin fairness: NUM_CH = 4, all valid continuously, DDR done 2 cycles after each ISSUE -> grant order 0,1,2,3,0,1; no channel is granted twice in a row.
3. Fixed priority (ARB_MODE = 0): ch0 and ch2 always valid -> ch0 is granted every time; ch2 is granted only after ch0 drops valid.
4. Timeout: TIMEOUT_CYCLES = 8, DDR never signals done -> resp_done for the owner with resp_err = 1 exactly 9 cycles after ISSUE; the arbiter returns to IDLE. Done arriving on the timeout cycle -> resp_err = 0.
5. Backpressure and reset:
   - ddr_ready = 0 with valid requests -> req_ready = 0 and no chip_enable.
   - Reset asserted during WAIT -> all outputs 0 the next cycle; a later ddr_operation_done produces no resp_done.
6. Write: ch0 writes data 0x1234.. to 0x100 -> chip_enable with write_enable = 1 and ddr_write_data = 0x1234..; inputs that change after fire do not alter the held DDR command.
